// File: rtl/nios_system_gpio_port.sv
// Avalon-MM GPIO slave: per-bit data/direction, synchronised inputs, sticky edge capture, maskable level IRQ.
// Define GPIO_PORT_SETCLR_EN to map atomic OUTSET (4) / OUTCLR (5) writes onto data_out.
module nios_system_gpio_port #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int              SYNC_STAGES = 2,
    parameter int              EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic [WIDTH-1:0] dir_reg, dir_next;
    logic [WIDTH-1:0] irqmask_reg, irqmask_next;
    logic [WIDTH-1:0] edgecap_reg, edgecap_next;
    logic [WIDTH-1:0] edgecap_clr;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] wr_data;
    logic [2:0]       prime_cnt_reg, prime_cnt_next;
    logic             primed;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_data      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign primed       = (prime_cnt_reg == PRIME_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [WIDTH-1:0] stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) stage_reg <= '0;
                    else          stage_reg <= in_port;
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) stage_reg <= '0;
                    else          stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign sync_s = g_sync[SYNC_STAGES-1].stage_reg;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_raw = sync_s & ~prev_reg;
            1:       edge_raw = ~sync_s & prev_reg;
            default: edge_raw = sync_s ^ prev_reg;
        endcase
    end

    always_comb begin
        data_out_next = data_out_reg;
        dir_next      = dir_reg;
        irqmask_next  = irqmask_reg;
        edgecap_clr   = '0;
        if (wr_en) begin
            case (address)
                3'd0: data_out_next = wr_data;
                3'd1: dir_next      = wr_data;
                3'd2: irqmask_next  = wr_data;
                3'd3: edgecap_clr   = wr_data;
`ifdef GPIO_PORT_SETCLR_EN
                3'd4: data_out_next = data_out_reg | wr_data;
                3'd5: data_out_next = data_out_reg & ~wr_data;
`endif
                default: ;
            endcase
        end
        // A fresh edge beats a simultaneous W1C so no event is ever lost.
        edgecap_next   = (edgecap_reg & ~edgecap_clr) | (primed ? edge_raw : '0);
        prime_cnt_next = primed ? prime_cnt_reg : prime_cnt_reg + 3'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg  <= RESET_VALUE;
            dir_reg       <= DIR_RESET;
            irqmask_reg   <= '0;
            edgecap_reg   <= '0;
            prev_reg      <= '0;
            prime_cnt_reg <= 3'd0;
        end else begin
            data_out_reg  <= data_out_next;
            dir_reg       <= dir_next;
            irqmask_reg   <= irqmask_next;
            edgecap_reg   <= edgecap_next;
            prev_reg      <= sync_s;
            prime_cnt_reg <= prime_cnt_next;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0] = (dir_reg & data_out_reg) | (~dir_reg & sync_s);
            3'd1:    readdata[WIDTH-1:0] = dir_reg;
            3'd2:    readdata[WIDTH-1:0] = irqmask_reg;
            3'd3:    readdata[WIDTH-1:0] = edgecap_reg;
            default: ;
        endcase
    end

    assign out_port = data_out_reg;
    assign oe       = dir_reg;
    assign irq      = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_nios_system_gpio_port.sv
// Self-checking bench for nios_system_gpio_port: directed table, hand-timed corner cases,
// and randomized traffic compared against a pin-history reference model.
module tb_nios_system_gpio_port;

    localparam int         W  = 8;
    localparam int         S  = 2;
    localparam int         ET = 0;
    localparam logic [7:0] RV = 8'hA5;
    localparam logic [7:0] DR = 8'h0F;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    nios_system_gpio_port #(
        .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(DR), .SYNC_STAGES(S), .EDGE_TYPE(ET)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pin samples kept as a history; the synced value is the pin
    // as sampled S-1 edges ago and "prev" is the one before that.
    logic [7:0] m_data, m_dir, m_mask, m_cap;
    logic [7:0] m_hist [0:S];
    int         m_cycles;

    function automatic logic [7:0] f_edges();
        logic [7:0] s, p;
        s = m_hist[S-1];
        p = m_hist[S];
        if (m_cycles <= S) return 8'h00;
        case (ET)
            0:       return s & ~p;
            1:       return ~s & p;
            default: return s ^ p;
        endcase
    endfunction

    function automatic logic [7:0] f_clr();
        if (chipselect && !write_n && address == 3'd3) return writedata[7:0];
        return 8'h00;
    endfunction

    function automatic logic [7:0] f_data_next();
        if (chipselect && !write_n) begin
            if (address == 3'd0) return writedata[7:0];
`ifdef GPIO_PORT_SETCLR_EN
            if (address == 3'd4) return m_data | writedata[7:0];
            if (address == 3'd5) return m_data & ~writedata[7:0];
`endif
        end
        return m_data;
    endfunction

    function automatic logic [31:0] f_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, (m_dir & m_data) | (~m_dir & m_hist[S-1])};
            3'd1:    return {24'h0, m_dir};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data   <= RV;
            m_dir    <= DR;
            m_mask   <= 8'h00;
            m_cap    <= 8'h00;
            m_cycles <= 0;
            for (int i = 0; i <= S; i++) m_hist[i] <= 8'h00;
        end else begin
            m_cycles <= m_cycles + 1;
            m_data   <= f_data_next();
            if (chipselect && !write_n && address == 3'd1) m_dir  <= writedata[7:0];
            if (chipselect && !write_n && address == 3'd2) m_mask <= writedata[7:0];
            m_cap     <= (m_cap & ~f_clr()) | f_edges();
            m_hist[0] <= in_port;
            for (int i = 1; i <= S; i++) m_hist[i] <= m_hist[i-1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] exp_setclr;

    initial begin
        vecs[0] = '{3'd1, 32'h0000_00F0, 3'd1, 32'h0000_00F0, 8'hA5};
        vecs[1] = '{3'd0, 32'h0000_003C, 3'd0, 32'h0000_0031, 8'h3C};
        vecs[2] = '{3'd2, 32'h0000_005A, 3'd2, 32'h0000_005A, 8'h3C};
        vecs[3] = '{3'd0, 32'hFFFF_FF00, 3'd0, 32'h0000_0001, 8'h00};
        vecs[4] = '{3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 8'h00};
        vecs[5] = '{3'd2, 32'h0000_0000, 3'd2, 32'h0000_0000, 8'h00};
        vecs[6] = '{3'd1, 32'hFFFF_FFFF, 3'd1, 32'h0000_00FF, 8'h00};
        vecs[7] = '{3'd0, 32'h0000_00A5, 3'd0, 32'h0000_00A5, 8'hA5};
        vecs[8] = '{3'd1, 32'h0000_0000, 3'd0, 32'h0000_0081, 8'hA5};

        reset_n    = 1'b0;
        in_port    = 8'hFF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;

        // Reset with pins held high; priming must suppress any capture.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", {24'h0, out_port}, 32'h0000_00A5);
        check("rst_oe", {24'h0, oe}, 32'h0000_000F);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (S + 4) @(negedge clk);
        address = 3'd3;
        #1;
        check("rst_edgecap", readdata, 32'h0);
        check("rst_irq_primed", {31'h0, irq}, 32'h0);

        in_port = 8'h81;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            address = vecs[i].raddr;
            @(negedge clk);
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
        end

        // Latency of a rising edge on bit 0 sampled at edge k.
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h01);
        address = 3'd0;
        @(negedge clk);
        in_port = 8'h01;
        @(negedge clk);
        check("lat_data_k", readdata, 32'h00);
        @(negedge clk);
        check("lat_data_k1", readdata, 32'h01);
        check("lat_irq_k1", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("lat_irq_k2", {31'h0, irq}, 32'h1);
        address = 3'd3;
        #1;
        check("lat_cap_k2", readdata, 32'h01);
        wr(3'd3, 32'h01);
        @(negedge clk);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        check("w1c_cap", readdata, 32'h00);

        // Masking a pending bit drops irq.
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        in_port = 8'h01;
        repeat (4) @(negedge clk);
        check("irq_again", {31'h0, irq}, 32'h1);
        wr(3'd2, 32'h00);
        @(negedge clk);
        check("irq_masked", {31'h0, irq}, 32'h0);
        address = 3'd3;
        #1;
        check("cap_sticky", readdata, 32'h01);

        // Rising edge on bit 2 lands on the same edge as a W1C of bit 2.
        wr(3'd3, 32'hFF);
        @(negedge clk);
        in_port = 8'h05;
        @(negedge clk);
        @(negedge clk);
        address    = 3'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h04;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        check("set_wins", readdata, 32'h04);

        // Atomic set/clear, or unmapped addresses in the default build.
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'h30);
        wr(3'd5, 32'h03);
        @(negedge clk);
`ifdef GPIO_PORT_SETCLR_EN
        exp_setclr = 8'h3C;
`else
        exp_setclr = 8'h0F;
`endif
        check("setclr_out", {24'h0, out_port}, {24'h0, exp_setclr});
        address = 3'd4;
        #1;
        check("rd_addr4", readdata, 32'h0);
        address = 3'd5;
        #1;
        check("rd_addr5", readdata, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rnd%0d_out", n), {24'h0, out_port}, {24'h0, m_data});
            check($sformatf("rnd%0d_oe", n), {24'h0, oe}, {24'h0, m_dir});
            check($sformatf("rnd%0d_irq", n), {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
            check($sformatf("rnd%0d_rd%0d", n, address), readdata, f_read(address));
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Asynchronous reset mid-operation, then priming restarts.
        wr(3'd2, 32'hFF);
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        in_port = 8'hFF;
        repeat (4) @(negedge clk);
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        address = 3'd3;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out", {24'h0, out_port}, 32'h0000_00A5);
        check("mid_rst_oe", {24'h0, oe}, 32'h0000_000F);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_cap", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (S + 4) @(negedge clk);
        check("reprime_cap", readdata, 32'h0);
        check("reprime_model", readdata, f_read(3'd3));
        check("reprime_irq", {31'h0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
